// File: rtl/output_load_sequencer.sv
// Unload sequencer for the PIM output buffer: walks result words out
// through a small FIFO and hands them to the core over valid/ready.
module output_load_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [2:0]  mode_i,
    input  logic        flush_i,
    output logic        load_en_o,
    output logic [4:0]  load_cnt_o,
    input  logic [31:0] output_buffer_i,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] MODE_READ     = 3'b011;
    localparam logic [2:0] MODE_PARALLEL = 3'b101;
    localparam logic [2:0] MODE_RBR      = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [5:0]    total_q, total_d;
    logic [5:0]    issued_q, issued_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic          fifo_full;
    logic          push, pop;
    logic          last_push;
    logic          drain_empty;
    logic          mode_ok;
    logic [5:0]    mode_total;

    always_comb begin
        mode_ok    = 1'b1;
        mode_total = 6'd32;
        unique case (mode_i)
            MODE_READ:     mode_total = 6'd1;
            MODE_PARALLEL: mode_total = 6'd32;
            MODE_RBR:      mode_total = 6'd32;
            default:       mode_ok    = 1'b0;
        endcase
    end

    // Full check uses the pre-pop count, so a full FIFO never pushes.
    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign load_en_o   = (state_q == LOAD) && !fifo_full;
    assign push        = load_en_o;
    assign pop         = rvalid_o && rready_i;
    assign last_push   = push && (issued_q == total_q - 6'd1);
    assign drain_empty = (count_q == '0) || ((count_q == CW'(1)) && pop);

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        issued_d = issued_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (flush_i) begin
            state_d  = IDLE;
            issued_d = 6'd0;
            cnt_d    = 5'd31;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i && mode_ok) begin
                        total_d  = mode_total;
                        issued_d = 6'd0;
                        cnt_d    = 5'd31;
                        state_d  = LOAD;
                    end else if (start_i) begin
                        err_d = 1'b1;
                    end
                end
                LOAD: begin
                    if (push) begin
                        issued_d = issued_q + 6'd1;
                        if (last_push) begin
                            cnt_d   = 5'd31;
                            state_d = DRAIN;
                        end else if (total_q != 6'd1) begin
                            cnt_d = cnt_q - 5'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            total_q  <= 6'd1;
            issued_q <= 6'd0;
            cnt_q    <= 5'd31;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            issued_q <= issued_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= output_buffer_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign load_cnt_o = cnt_q;
    assign rdata_o    = mem_q[rd_ptr_q];
    assign rvalid_o   = (count_q != '0);
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_output_load_sequencer.sv
// Directed bench for output_load_sequencer: table of unload scenarios
// plus hand-written flush, restart and mid-drain reset sequences.
module tb_output_load_sequencer;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [2:0]  mode_i;
    logic        flush_i;
    logic        load_en_o;
    logic [4:0]  load_cnt_o;
    logic [31:0] output_buffer_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        rready_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    logic        rd_mode;
    int          n_tests = 0;
    int          n_fail  = 0;

    output_load_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .mode_i          (mode_i),
        .flush_i         (flush_i),
        .load_en_o       (load_en_o),
        .load_cnt_o      (load_cnt_o),
        .output_buffer_i (output_buffer_i),
        .rdata_o         (rdata_o),
        .rvalid_o        (rvalid_o),
        .rready_i        (rready_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    // Output buffer model: word k sits at load_cnt = 31 - k.
    assign output_buffer_i = rd_mode ? 32'hDEADBEEF
                                     : {27'h0, 5'd31 - load_cnt_o};

    typedef struct {
        logic [2:0] mode;
        int         stall;
        int         words;
        int         first_pop;
        int         done_cyc;
        bit         err;
        int         hold_cyc;
        logic [4:0] hold_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " load_en"}, 32'(load_en_o), 32'd0);
        check({tag, " load_cnt"}, 32'(load_cnt_o), 32'd31);
        check({tag, " rdata"}, rdata_o, 32'd0);
        check({tag, " rvalid"}, 32'(rvalid_o), 32'd0);
        check({tag, " busy"}, 32'(busy_o), 32'd0);
        check({tag, " done"}, 32'(done_o), 32'd0);
        check({tag, " err"}, 32'(err_o), 32'd0);
    endtask

    task automatic run(input vec_t v);
        int pushes = 0;
        int pops   = 0;
        int first  = 0;
        rd_mode = (v.mode == 3'b011);
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        mode_i   = v.mode;
        rready_i = (v.stall <= 0);
        @(negedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            start_i  = 1'b0;
            rready_i = (c >= v.stall);
            @(negedge clk);
            check("busy", 32'(busy_o), 32'(c < v.done_cyc));
            check("done", 32'(done_o), 32'(c == v.done_cyc));
            check("err", 32'(err_o), 32'(v.err && c == 1));
            if (load_en_o) begin
                check("load_cnt", 32'(load_cnt_o),
                      rd_mode ? 32'd31 : 32'(31 - pushes));
                pushes++;
            end
            if (rvalid_o && rready_i) begin
                if (first == 0) first = c;
                check("rdata", rdata_o,
                      rd_mode ? 32'hDEADBEEF : 32'(pops));
                pops++;
            end
            if (c == v.hold_cyc) begin
                check("hold_en", 32'(load_en_o), 32'd0);
                check("hold_cnt", 32'(load_cnt_o), 32'(v.hold_cnt));
            end
        end
        check("pushes", 32'(pushes), 32'(v.words));
        check("pops", 32'(pops), 32'(v.words));
        check("first_pop", 32'(first), 32'(v.first_pop));
    endtask

    initial begin
        vecs[0] = '{3'b101, 0, 32, 2, 34, 1'b0, 0, 5'd0};
        vecs[1] = '{3'b011, 0, 1, 2, 3, 1'b0, 0, 5'd0};
        vecs[2] = '{3'b110, 10, 32, 10, 42, 1'b0, 7, 5'd27};
        vecs[3] = '{3'b011, 3, 1, 3, 4, 1'b0, 0, 5'd0};
        vecs[4] = '{3'b000, 0, 0, 0, 0, 1'b1, 0, 5'd0};
        vecs[5] = '{3'b111, 0, 0, 0, 0, 1'b1, 0, 5'd0};

        rst_ni   = 1'b0;
        start_i  = 1'b0;
        mode_i   = 3'b000;
        flush_i  = 1'b0;
        rready_i = 1'b0;
        rd_mode  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(negedge clk);
        check_idle("reset");

        foreach (vecs[i]) run(vecs[i]);

        // Flush in cycle 12 of a PARALLEL unload.
        rd_mode = 1'b0;
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        mode_i   = 3'b101;
        rready_i = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            flush_i = (c == 12);
            @(negedge clk);
            if (c == 13) begin
                check("flush busy", 32'(busy_o), 32'd0);
                check("flush rvalid", 32'(rvalid_o), 32'd0);
                check("flush load_cnt", 32'(load_cnt_o), 32'd31);
                check("flush load_en", 32'(load_en_o), 32'd0);
            end
            if (c >= 13) check("flush done", 32'(done_o), 32'd0);
            if (c >= 13) check("flush err", 32'(err_o), 32'd0);
        end
        run(vecs[0]);

        // Start pulses during LOAD, then reset while stuck in DRAIN.
        rd_mode = 1'b0;
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        mode_i   = 3'b101;
        rready_i = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk);
            #1;
            start_i  = (c == 2 || c == 3);
            mode_i   = (c == 2) ? 3'b011 : 3'b000;
            rready_i = (c >= 6 && c < 35) || c >= 39;
            rst_ni   = (c != 37);
            @(negedge clk);
            if (c <= 5) check("ign err", 32'(err_o), 32'd0);
            if (c == 5) begin
                check("ign load_cnt", 32'(load_cnt_o), 32'd27);
                check("ign load_en", 32'(load_en_o), 32'd0);
                check("ign busy", 32'(busy_o), 32'd1);
            end
            if (c == 36) begin
                check("drain busy", 32'(busy_o), 32'd1);
                check("drain load_en", 32'(load_en_o), 32'd0);
                check("drain rvalid", 32'(rvalid_o), 32'd1);
            end
            if (c == 38) check_idle("mid reset");
            check("rst done", 32'(done_o), 32'd0);
            if (c >= 38) check("rst busy", 32'(busy_o), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/output_load_sequencer.md
# output_load_sequencer

Sequencer and elastic buffer that sits directly downstream of the PIM output buffer. After a PIM operation finishes, it drives the buffer's load enable and load count to walk the result words out. It captures each 32-bit word into a small FIFO and presents the words to the core over a valid/ready handshake. Back-pressure from the core stalls the walk, so no word is ever lost.

## Interface
Parameters:
- FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2.

Ports:
- clk_i  input  1  single clock for the block.
- rst_ni  input  1  synchronous, active-low reset.
- start_i  input  1  single-cycle request to unload the results of the last operation; sampled only in IDLE.
- mode_i  input  3  mode of the finished operation: 3'b011 READ, 3'b101 PARALLEL, 3'b110 RBR; sampled with start_i.
- flush_i  input  1  abort; any state returns to IDLE and the FIFO is emptied.
- load_en_o  output  1  load enable to the output buffer.
- load_cnt_o  output  5  load count to the output buffer; word k is selected by load_cnt = 31 - k.
- output_buffer_i  input  32  word returned combinationally by the output buffer in the same cycle.
- rdata_o  output  32  FIFO head word.
- rvalid_o  output  1  FIFO non-empty.
- rready_i  input  1  core accepts rdata_o.
- busy_o  output  1  state is not IDLE.
- done_o  output  1  one-cycle pulse when the unload has completed.
- err_o  output  1  one-cycle pulse when start_i arrives with an unsupported mode.

## Operation
- States: IDLE, LOAD, DRAIN.
- IDLE, start_i with a valid mode:
  - Latch the word total N (READ → 1, PARALLEL/RBR → 32).
  - Set the issued counter to 0 and load_cnt_o to 31.
  - Go to LOAD.
- IDLE, start_i with any other mode: err_o = 1 for the next cycle; stay in IDLE.
- start_i outside IDLE is ignored.
- LOAD:
  - load_en_o = !fifo_full. It is combinational from registered state and FIFO count.
  - Push: when load_en_o = 1, output_buffer_i is written into the FIFO at the same clock edge.
  - On each push, load_cnt_o decrements by 1 and the issued counter increments.
  - After the push of word N-1, go to DRAIN.
  - In READ mode, load_cnt_o stays 31; the output buffer ignores it.
- FIFO full and pop in the same cycle: no push that cycle. The full check uses the pre-pop count.
- Pop: rvalid_o && rready_i. rdata_o is the head entry, read from registered storage.
- DRAIN: load_en_o = 0. When the FIFO count is 0, go to IDLE and pulse done_o in the following cycle.
- flush_i has priority over start_i and over every transition:
  - Next state is IDLE, FIFO pointers and count clear, load_cnt_o returns to 31.
  - No done_o pulse; no err_o pulse.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is FIFO_DEPTH+1 values wide.

## Timing
- Reset values:
  - State IDLE, FIFO empty.
  - load_en_o 0, load_cnt_o 31, rdata_o 0, rvalid_o 0.
  - busy_o 0, done_o 0, err_o 0.
- Reset mid-operation behaves exactly like flush_i. Reset is synchronous.
- start_i is sampled at edge 0. LOAD holds from cycle 1, where load_en_o = 1 and load_cnt_o = 31.
- A push at edge t makes rvalid_o visible in cycle t+1.
- With rready_i held at 1:
  - PARALLEL/RBR: pushes in cycles 1-32, pops in cycles 2-33, done_o in cycle 34.
  - READ: push in cycle 1, pop in cycle 2, done_o in cycle 3.
- busy_o is high from cycle 1 through the cycle before done_o.
- Throughput is one word per cycle with no bubbles while the core never stalls.

## Test plan
- PARALLEL unload, rready_i = 1, output_buffer_i = {27'h0, 5'd31 - load_cnt_o} → rdata_o carries 0,1,…,31 in cycles 2-33; load_cnt_o steps 31→0; done_o in cycle 34 only.
- READ unload, output_buffer_i = 32'hDEADBEEF → exactly one push, with load_cnt_o = 31; rdata_o = 32'hDEADBEEF in cycle 2; done_o in cycle 3.
- RBR unload with rready_i = 0 until cycle 10 →
  - Pushes in cycles 1-4, then load_en_o = 0 and load_cnt_o holds at 27.
  - From cycle 10, the 32 words arrive in order with none lost or duplicated.
- mode_i = 3'b000 with start_i → err_o in the next cycle; load_en_o never asserts; busy_o stays 0.
- flush_i in cycle 12 of a PARALLEL unload → IDLE in cycle 13 with rvalid_o = 0, load_cnt_o = 31, and no done_o. A new start then completes normally.
- start_i pulses during LOAD, plus rst_ni low for one cycle mid-DRAIN → the start pulses are ignored; after the reset, all outputs are at reset values.
